// File: rtl/nearest_decimation_if.sv
// Pixel stream bundle: per/post vsync, href, clken framing plus one YCbCr444 pixel.
// Latency: none, wires only.
// Backpressure: none; clken alone paces the stream.
interface nearest_decimation_if;
    logic       frame_vsync;
    logic       frame_href;
    logic       frame_clken;
    logic [7:0] img_Y;
    logic [7:0] img_Cb;
    logic [7:0] img_Cr;

    modport master (
        output frame_vsync, frame_href, frame_clken,
        output img_Y, img_Cb, img_Cr
    );

    modport slave (
        input frame_vsync, frame_href, frame_clken,
        input img_Y, img_Cb, img_Cr
    );
endinterface

// File: rtl/nearest_decimation.sv
// Nearest-neighbour YCbCr444 downscaler; keeps source columns/rows chosen by fixed-point accumulators.
// Latency: 1 clock from an accepted input pixel to its output pixel.
// Backpressure: none; dropped pixels are not forwarded, short lines/frames just yield fewer outputs.
module nearest_decimation #(
    parameter logic [10:0] C_SRC_IMG_WIDTH  = 11'd1024,
    parameter logic [10:0] C_SRC_IMG_HEIGHT = 11'd768,
    parameter logic [10:0] C_DST_IMG_WIDTH  = 11'd640,
    parameter logic [10:0] C_DST_IMG_HEIGHT = 11'd480,
    parameter logic [17:0] C_X_RATIO        = 18'd104857,
    parameter logic [17:0] C_Y_RATIO        = 18'd104857
) (
    input  logic                        clk,
    input  logic                        rst,
    nearest_decimation_if.slave         per,
    nearest_decimation_if.master        post,
    output logic                        fmt_err
);

    // A kept-count of up to 2047 times an 18-bit ratio stays below 2^29, so
    // 30 bits can never wrap; the integer part is everything above bit 16.
    localparam int ACC_W = 30;
    localparam int INT_W = ACC_W - 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               vs_q, hs_q;
    logic [10:0]        ix_q, ix_d, ox_q, ox_d;
    logic [10:0]        iy_q, iy_d, oy_q, oy_d;
    logic [ACC_W-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic               fmt_err_q, fmt_err_d;
    logic               post_vs_q, post_hs_q, post_ck_q;
    logic [7:0]         y_q, cb_q, cr_q;

    logic               vs_rise, vs_fall, hs_fall, active;
    logic               pix_acc, keep_line, keep_px;

    // Edge detection against the registered framing, plus the column/row keep decisions.
    always_comb begin
        vs_rise   = per.frame_vsync & ~vs_q;
        vs_fall   = ~per.frame_vsync & vs_q;
        hs_fall   = ~per.frame_href & hs_q;
        active    = (state_q == ACTIVE);
        pix_acc   = per.frame_href & per.frame_clken;
        keep_line = ({{(INT_W-11){1'b0}}, iy_q} == acc_y_q[ACC_W-1:16]) &&
                    (oy_q < C_DST_IMG_HEIGHT);
        keep_px   = active && !vs_rise && pix_acc && keep_line &&
                    ({{(INT_W-11){1'b0}}, ix_q} == acc_x_q[ACC_W-1:16]) &&
                    (ox_q < C_DST_IMG_WIDTH);
    end

    // Next state for FSM and counters; a frame start overrides any line end in the same cycle.
    always_comb begin
        state_d   = state_q;
        ix_d      = ix_q;
        ox_d      = ox_q;
        acc_x_d   = acc_x_q;
        iy_d      = iy_q;
        oy_d      = oy_q;
        acc_y_d   = acc_y_q;
        fmt_err_d = 1'b0;

        if (vs_rise) begin
            state_d = ACTIVE;
            ix_d    = '0;
            ox_d    = '0;
            acc_x_d = '0;
            iy_d    = '0;
            oy_d    = '0;
            acc_y_d = '0;
        end else if (active) begin
            if (vs_fall) begin
                state_d = IDLE;
            end
            if (hs_fall) begin
                fmt_err_d = (ix_q != C_SRC_IMG_WIDTH);
                if (iy_q != 11'h7FF) begin
                    iy_d = iy_q + 11'd1;
                end
                if (keep_line) begin
                    oy_d    = oy_q + 11'd1;
                    acc_y_d = acc_y_q + ACC_W'(C_Y_RATIO);
                end
                ix_d    = '0;
                ox_d    = '0;
                acc_x_d = '0;
            end else if (pix_acc) begin
                if (keep_px) begin
                    ox_d    = ox_q + 11'd1;
                    acc_x_d = acc_x_q + ACC_W'(C_X_RATIO);
                end
                if (ix_q != 11'h7FF) begin
                    ix_d = ix_q + 11'd1;
                end
            end
        end
    end

    // State, counters and registered outputs. vs_q resets high so a frame already
    // in flight when reset lifts is not mistaken for a new frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vs_q      <= 1'b1;
            hs_q      <= 1'b0;
            ix_q      <= '0;
            ox_q      <= '0;
            acc_x_q   <= '0;
            iy_q      <= '0;
            oy_q      <= '0;
            acc_y_q   <= '0;
            fmt_err_q <= 1'b0;
            post_vs_q <= 1'b0;
            post_hs_q <= 1'b0;
            post_ck_q <= 1'b0;
            y_q       <= '0;
            cb_q      <= '0;
            cr_q      <= '0;
        end else begin
            state_q   <= state_d;
            vs_q      <= per.frame_vsync;
            hs_q      <= per.frame_href;
            ix_q      <= ix_d;
            ox_q      <= ox_d;
            acc_x_q   <= acc_x_d;
            iy_q      <= iy_d;
            oy_q      <= oy_d;
            acc_y_q   <= acc_y_d;
            fmt_err_q <= fmt_err_d;
            post_vs_q <= per.frame_vsync & (active | vs_rise);
            post_hs_q <= per.frame_href & keep_line & active;
            post_ck_q <= keep_px;
            if (keep_px) begin
                y_q  <= per.img_Y;
                cb_q <= per.img_Cb;
                cr_q <= per.img_Cr;
            end
        end
    end

    assign post.frame_vsync = post_vs_q;
    assign post.frame_href  = post_hs_q;
    assign post.frame_clken = post_ck_q;
    assign post.img_Y       = y_q;
    assign post.img_Cb      = cb_q;
    assign post.img_Cr      = cr_q;
    assign fmt_err          = fmt_err_q;

endmodule

// File: tb/tb_nearest_decimation.sv
// Scoreboard bench for nearest_decimation at a reduced 64x48 -> 40x30 geometry (same 1.6 ratio).
// Latency: expects every kept pixel and every fmt_err exactly 1 clock after its input.
// Backpressure: none; the driver paces the stream with href/clken gaps only.
module tb_nearest_decimation;

    localparam int     SW    = 64;
    localparam int     SH    = 48;
    localparam int     DW    = 40;
    localparam int     DH    = 30;
    localparam longint RATIO = 104857;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fmt_err;

    nearest_decimation_if per_bus();
    nearest_decimation_if post_bus();

    nearest_decimation #(
        .C_SRC_IMG_WIDTH (11'd64),
        .C_SRC_IMG_HEIGHT(11'd48),
        .C_DST_IMG_WIDTH (11'd40),
        .C_DST_IMG_HEIGHT(11'd30),
        .C_X_RATIO       (18'd104857),
        .C_Y_RATIO       (18'd104857)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .per    (per_bus),
        .post   (post_bus),
        .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] dat;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          fmt_q[$];
    logic [23:0] out_log[$];

    int checks = 0, failures = 0;
    bit quiet = 1'b1;
    int hs_cnt = 0, vs_cnt = 0, fmt_cnt = 0, quiet_viol = 0, hold_viol = 0;
    int exp_hs = 0, exp_vs = 0;
    bit keep_col[SW];
    bit keep_row[SH];

    int y_tab[8]  = '{0, 1, 3, 4, 6, 7, 9, 11};
    int cb_tab[5] = '{0, 1, 3, 4, 6};

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [23:0] log_at(input int i);
        if (i >= 0 && i < out_log.size()) return out_log[i];
        return 24'hFFFFFF;
    endfunction

    // ---------------- monitor ----------------
    logic [23:0] mon_dat;
    logic [23:0] last_dat = '0;
    bit          prev_hs = 1'b0, prev_vs = 1'b0;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge clk);
            mon_dat = {post_bus.img_Y, post_bus.img_Cb, post_bus.img_Cr};
            if (quiet) begin
                if (post_bus.frame_vsync || post_bus.frame_href || post_bus.frame_clken ||
                    fmt_err || mon_dat != 24'd0)
                    quiet_viol++;
                last_dat = '0;
            end else begin
                if (post_bus.frame_clken) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", longint'(mon_dat), -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pix_data", longint'({post_bus.frame_href, mon_dat}),
                            longint'({1'b1, mon_e.dat}));
                        chk("pix_time", cyc, mon_e.cyc);
                    end
                    out_log.push_back(mon_dat);
                    last_dat = mon_dat;
                end else if (mon_dat != last_dat) begin
                    hold_viol++;
                end
                if (fmt_err) begin
                    fmt_cnt++;
                    if (fmt_q.size() == 0) chk("unexpected_fmt_err", cyc, -1);
                    else chk("fmt_err_time", cyc, fmt_q.pop_front());
                end
                if (post_bus.frame_href && !prev_hs) hs_cnt++;
                if (post_bus.frame_vsync && !prev_vs) vs_cnt++;
            end
            prev_hs = post_bus.frame_href;
            prev_vs = post_bus.frame_vsync;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int line, input int len, input bit gaps,
                              input logic [7:0] cr, input int rst_at);
        exp_t e;
        int   g;
        if (!quiet && keep_row[line]) exp_hs++;
        for (int p = 0; p < len; p++) begin
            if (gaps) begin
                g = 0;
                while ($urandom_range(0, 1) == 1 && g < 8) begin
                    step();
                    per_bus.frame_href  = 1'b1;
                    per_bus.frame_clken = 1'b0;
                    per_bus.img_Y       = 8'($urandom);
                    per_bus.img_Cb      = 8'($urandom);
                    per_bus.img_Cr      = 8'($urandom);
                    g++;
                end
            end
            if (p == rst_at) begin
                step();
                rst                 = 1'b1;
                per_bus.frame_clken = 1'b0;
                step();
                rst   = 1'b0;
                quiet = 1'b1;
            end
            step();
            per_bus.frame_href  = 1'b1;
            per_bus.frame_clken = 1'b1;
            per_bus.img_Y       = 8'(p);
            per_bus.img_Cb      = 8'(line);
            per_bus.img_Cr      = cr;
            if (!quiet && keep_row[line] && keep_col[p]) begin
                e.dat = {8'(p), 8'(line), cr};
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
        end
        step();
        per_bus.frame_href  = 1'b0;
        per_bus.frame_clken = 1'b0;
        if (!quiet && len != SW) fmt_q.push_back(cyc + 1);
        repeat (3) step();
    endtask

    task automatic drive_frame(input logic [7:0] cr, input bit gaps, input int short_line,
                               input int rst_line, input bit stray);
        if (stray) begin
            for (int i = 0; i < 5; i++) begin
                step();
                per_bus.frame_vsync = 1'b0;
                per_bus.frame_href  = 1'b1;
                per_bus.frame_clken = 1'b1;
                per_bus.img_Y       = 8'(100 + i);
            end
            step();
            per_bus.frame_href  = 1'b0;
            per_bus.frame_clken = 1'b0;
            per_bus.frame_vsync = 1'b1;
            quiet               = 1'b0;
        end else begin
            step();
            per_bus.frame_vsync = 1'b1;
            quiet               = 1'b0;
        end
        exp_vs++;
        repeat (4) step();
        for (int line = 0; line < SH; line++) begin
            drive_line(line, (line == short_line) ? SW - 4 : SW, gaps, cr,
                       (line == rst_line) ? 10 : -1);
        end
        step();
        per_bus.frame_vsync = 1'b0;
        repeat (10) step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          base, hs_base, fmt_base, cnt;
        logic [23:0] d;

        per_bus.frame_vsync = 1'b0;
        per_bus.frame_href  = 1'b0;
        per_bus.frame_clken = 1'b0;
        per_bus.img_Y       = '0;
        per_bus.img_Cb      = '0;
        per_bus.img_Cr      = '0;
        for (int n = 0; n < DW; n++) keep_col[int'((longint'(n) * RATIO) >>> 16)] = 1'b1;
        for (int n = 0; n < DH; n++) keep_row[int'((longint'(n) * RATIO) >>> 16)] = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vsync", post_bus.frame_vsync, 0);
        chk("rst_href",  post_bus.frame_href,  0);
        chk("rst_clken", post_bus.frame_clken, 0);
        chk("rst_Y",     post_bus.img_Y,       0);
        chk("rst_Cb",    post_bus.img_Cb,      0);
        chk("rst_Cr",    post_bus.img_Cr,      0);
        chk("rst_fmt",   fmt_err,              0);

        // Frame A: full frame, continuous clken
        base = out_log.size(); hs_base = hs_cnt;
        drive_frame(8'd1, 1'b0, -1, -1, 1'b0);
        chk("frameA_pixels", out_log.size() - base, DW * DH);
        chk("frameA_lines", hs_cnt - hs_base, DH);
        for (int i = 0; i < 8; i++) begin
            d = log_at(base + i);
            chk("first_line_y", d[23:16], y_tab[i]);
        end
        for (int k = 0; k < 5; k++) begin
            d = log_at(base + DW * k);
            chk("kept_line_cb", d[15:8], cb_tab[k]);
        end
        d = log_at(base + DW * DH - 1);
        chk("last_pixel_y", d[23:16], 62);
        chk("last_line_cb", d[15:8], 46);

        // Frame B: same frame with random clken gaps
        base = out_log.size(); hs_base = hs_cnt;
        drive_frame(8'd2, 1'b1, -1, -1, 1'b0);
        chk("frameB_pixels", out_log.size() - base, DW * DH);
        chk("frameB_lines", hs_cnt - hs_base, DH);

        // Frame C: line 6 is 60 pixels long
        base = out_log.size(); fmt_base = fmt_cnt;
        drive_frame(8'd3, 1'b0, 6, -1, 1'b0);
        cnt = 0;
        for (int i = base; i < out_log.size(); i++) begin
            d = out_log[i];
            if (d[15:8] == 8'd6) cnt++;
        end
        chk("short_line_pixels", cnt, 38);
        chk("frameC_pixels", out_log.size() - base, DW * DH - 2);
        chk("frameC_fmt_pulses", fmt_cnt - fmt_base, 1);

        // Frame D: reset in the middle of line 20
        drive_frame(8'd4, 1'b0, -1, 20, 1'b0);
        chk("quiet_after_reset", quiet_viol, 0);

        // Frame E: full frame after the reset
        base = out_log.size(); hs_base = hs_cnt;
        drive_frame(8'd5, 1'b0, -1, -1, 1'b0);
        chk("frameE_pixels", out_log.size() - base, DW * DH);
        chk("frameE_lines", hs_cnt - hs_base, DH);

        // Frame F: vsync rises on the same cycle a stray line's href falls
        base = out_log.size(); hs_base = hs_cnt;
        drive_frame(8'd6, 1'b0, -1, -1, 1'b1);
        chk("frameF_pixels", out_log.size() - base, DW * DH);
        chk("frameF_lines", hs_cnt - hs_base, DH);
        d = log_at(base);
        chk("frameF_first_cb", d[15:8], 0);

        chk("exp_queue_drained", exp_q.size(), 0);
        chk("fmt_queue_drained", fmt_q.size(), 0);
        chk("data_hold", hold_viol, 0);
        chk("quiet_total", quiet_viol, 0);
        chk("vsync_frames", vs_cnt, exp_vs);
        chk("href_lines_total", hs_cnt, exp_hs);
        chk("fmt_total", fmt_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
